// File: rtl/fetch_hazard_ctrl_if.sv
// Bundle of hazard inputs and pipeline-control outputs between the
// datapath (master) and the fetch/decode hazard controller (slave).
interface fetch_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             ex_mem_read;
   logic [4:0]       ex_rt;
   logic             branch_taken;
   logic             jump;
   logic             halt_instr;
   logic             resume;
   logic             ext_stall;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, jump, halt_instr, resume, ext_stall,
      input  pc_en, if_id_en, if_id_flush, id_ex_flush, halted, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
             branch_taken, jump, halt_instr, resume, ext_stall,
      output pc_en, if_id_en, if_id_flush, id_ex_flush, halted, stall_count
   );
endinterface

// File: rtl/fetch_hazard_ctrl.sv
// Fetch/decode boundary control: resolves load-use hazards, redirects,
// instruction-memory wait states, external freeze and halt/resume.
// Control outputs are Mealy (same-cycle); halted and stall_count are registered.
module fetch_hazard_ctrl #(
   parameter int WAIT_CYCLES = 0,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   fetch_hazard_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

   // wait_cnt is loaded with WAIT_CYCLES-1 so that count 0 is the last wait cycle
   localparam logic [3:0] WAIT_LD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_wait_cnt, w_wait_nxt;
   logic             r_halted;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_load_use, w_redirect;
   logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_flush;

   assign w_load_use = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                       ((bus.ex_rt == bus.id_rs) ||
                        (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
   assign w_redirect = bus.branch_taken || bus.jump;

   // State register: ext_stall freezes state and wait counter in place
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Next-state logic; every PC advance opens a wait window when one is configured
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      if (!bus.ext_stall) begin
         case (r_state)
            ST_RUN: begin
               if (w_load_use) begin
                  w_state_nxt = ST_RUN;
               end else if (bus.halt_instr) begin
                  w_state_nxt = ST_HALT;
               end else if (WAIT_CYCLES > 0) begin
                  w_state_nxt = ST_WAIT;
                  w_wait_nxt  = WAIT_LD;
               end
            end
            ST_WAIT: begin
               if (r_wait_cnt == 4'd0) w_state_nxt = ST_RUN;
               else                    w_wait_nxt  = r_wait_cnt - 4'd1;
            end
            ST_HALT: begin
               if (bus.resume) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
         endcase
      end
   end

   // Output logic: freeze and reset force every control low, else act on state
   always_comb begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      if (reset && !bus.ext_stall) begin
         case (r_state)
            ST_RUN: begin
               if (w_load_use) begin
                  w_id_ex_flush = 1'b1;
               end else if (bus.halt_instr) begin
                  w_if_id_flush = 1'b1;
               end else begin
                  w_pc_en       = 1'b1;
                  w_if_id_en    = 1'b1;
                  w_if_id_flush = w_redirect;
               end
            end
            ST_WAIT, ST_HALT: w_id_ex_flush = 1'b1;
            default: w_id_ex_flush = 1'b0;
         endcase
      end
   end

   // Halted flag and saturating stall counter; HALT cycles are not stalls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_halted    <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_halted <= (w_state_nxt == ST_HALT);
         if (!w_pc_en && (r_state != ST_HALT) && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.pc_en       = w_pc_en;
   assign bus.if_id_en    = w_if_id_en;
   assign bus.if_id_flush = w_if_id_flush;
   assign bus.id_ex_flush = w_id_ex_flush;
   assign bus.halted      = r_halted;
   assign bus.stall_count = r_stall_cnt;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench: two controllers (no wait states / 2 wait states with a
// narrow counter) share random stimulus; a reference model predicts each cycle.
module tb_fetch_hazard_ctrl;

   localparam int WA = 0, CA = 16;
   localparam int WB = 2, CB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_hazard_ctrl_if #(.CNT_W(CA)) ifa ();
   fetch_hazard_ctrl_if #(.CNT_W(CB)) ifb ();

   fetch_hazard_ctrl #(.WAIT_CYCLES(WA), .CNT_W(CA)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa.slave));
   fetch_hazard_ctrl #(.WAIT_CYCLES(WB), .CNT_W(CB)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb.slave));

   typedef struct {
      logic [3:0] ctl;     // {pc_en, if_id_en, if_id_flush, id_ex_flush}
      logic       halted;
      int         cnt;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int errors = 0;
   int checks = 0;

   // stimulus variables
   logic [4:0] rs, rt, ert;
   logic       uses_rt, emr, br, jmp, hlt, res, ext;

   // reference model state: mode 0=running 1=waiting 2=halted
   int m_mode[2], m_left[2], m_stalls[2];
   int m_wait[2] = '{WA, WB};
   int m_max[2]  = '{(1 << CA) - 1, (1 << CB) - 1};

   function automatic exp_t model_step(int d);
      exp_t e;
      bit lu, pc;
      int start;
      e.ctl = 4'b0000; e.halted = 1'b0; e.cnt = 0;
      if (!rst_n) begin
         m_mode[d] = 0; m_left[d] = 0; m_stalls[d] = 0;
         return e;
      end
      lu = emr && (ert != 0) && ((ert == rs) || (uses_rt && ert == rt));
      start = m_mode[d];
      e.halted = (start == 2);
      e.cnt = m_stalls[d];
      if (ext) begin
         e.ctl = 4'b0000;
      end else if (start == 0) begin
         if (lu)        e.ctl = 4'b0001;
         else if (hlt) begin e.ctl = 4'b0010; m_mode[d] = 2; end
         else if (br || jmp) e.ctl = 4'b1110;
         else           e.ctl = 4'b1100;
         if (e.ctl[3] && m_wait[d] > 0) begin
            m_mode[d] = 1;
            m_left[d] = m_wait[d];
         end
      end else if (start == 1) begin
         e.ctl = 4'b0001;
         m_left[d] = m_left[d] - 1;
         if (m_left[d] == 0) m_mode[d] = 0;
      end else begin
         e.ctl = 4'b0001;
         if (res) m_mode[d] = 0;
      end
      pc = e.ctl[3];
      if (!pc && start != 2 && m_stalls[d] < m_max[d]) m_stalls[d] = m_stalls[d] + 1;
      return e;
   endfunction

   task automatic clear_in();
      rs = 0; rt = 0; ert = 0; uses_rt = 0; emr = 0;
      br = 0; jmp = 0; hlt = 0; res = 0; ext = 0;
   endtask

   task automatic drive_if();
      ifa.id_rs = rs; ifa.id_rt = rt; ifa.ex_rt = ert; ifa.id_uses_rt = uses_rt;
      ifa.ex_mem_read = emr; ifa.branch_taken = br; ifa.jump = jmp;
      ifa.halt_instr = hlt; ifa.resume = res; ifa.ext_stall = ext;
      ifb.id_rs = rs; ifb.id_rt = rt; ifb.ex_rt = ert; ifb.id_uses_rt = uses_rt;
      ifb.ex_mem_read = emr; ifb.branch_taken = br; ifb.jump = jmp;
      ifb.halt_instr = hlt; ifb.resume = res; ifb.ext_stall = ext;
   endtask

   // one stimulus cycle: apply inputs after the edge and queue the predictions
   task automatic step(input logic rstv);
      @(posedge clk);
      #1;
      rst_n = rstv;
      drive_if();
      qa.push_back(model_step(0));
      qb.push_back(model_step(1));
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare every cycle the DUTs present a result on the falling edge
   always @(negedge clk) begin
      exp_t ea, eb;
      if (qa.size() > 0 && qb.size() > 0) begin
         ea = qa.pop_front();
         eb = qb.pop_front();
         check("a_ctl", int'({ifa.pc_en, ifa.if_id_en, ifa.if_id_flush, ifa.id_ex_flush}), int'(ea.ctl));
         check("a_halted", int'(ifa.halted), int'(ea.halted));
         check("a_stall_count", int'(ifa.stall_count), ea.cnt);
         check("b_ctl", int'({ifb.pc_en, ifb.if_id_en, ifb.if_id_flush, ifb.id_ex_flush}), int'(eb.ctl));
         check("b_halted", int'(ifb.halted), int'(eb.halted));
         check("b_stall_count", int'(ifb.stall_count), eb.cnt);
      end
   end

   initial begin
      clear_in();
      drive_if();
      m_mode = '{0, 0}; m_left = '{0, 0}; m_stalls = '{0, 0};
      // reset, then free-running fetch
      step(1'b0); step(1'b0);
      repeat (6) step(1'b1);
      // single load-use hazard on rs
      emr = 1; ert = 5; rs = 5; step(1'b1);
      clear_in(); repeat (3) step(1'b1);
      // ex_rt==0 and rt match without rt use: no hazard
      emr = 1; ert = 0; rs = 0; step(1'b1);
      rs = 1; ert = 5; rt = 5; uses_rt = 0; step(1'b1);
      uses_rt = 1; step(1'b1);
      clear_in(); repeat (3) step(1'b1);
      // branch alongside load-use: stall first, redirect next free cycle
      emr = 1; ert = 5; rs = 5; br = 1; step(1'b1);
      emr = 0; step(1'b1);
      clear_in(); repeat (3) step(1'b1);
      // freeze in the middle of a wait window
      step(1'b1); ext = 1; step(1'b1); step(1'b1); step(1'b1);
      ext = 0; repeat (5) step(1'b1);
      // halt, stay halted, resume, halt again then reset mid-HALT
      hlt = 1; step(1'b1);
      hlt = 0; repeat (5) step(1'b1);
      ext = 1; step(1'b1); ext = 0;
      res = 1; step(1'b1);
      res = 0; repeat (4) step(1'b1);
      hlt = 1; step(1'b1); hlt = 0; repeat (3) step(1'b1);
      step(1'b0); repeat (3) step(1'b1);
      // reset mid-WAIT
      step(1'b1); step(1'b0); repeat (4) step(1'b1);
      // resume outside HALT ignored
      res = 1; repeat (3) step(1'b1); res = 0;
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rs      = 5'($urandom_range(0, 3));
         rt      = 5'($urandom_range(0, 3));
         ert     = 5'($urandom_range(0, 3));
         uses_rt = 1'($urandom_range(0, 1));
         emr     = ($urandom_range(0, 2) == 0);
         br      = ($urandom_range(0, 5) == 0);
         jmp     = ($urandom_range(0, 7) == 0);
         hlt     = ($urandom_range(0, 19) == 0);
         res     = ($urandom_range(0, 3) == 0);
         ext     = ($urandom_range(0, 7) == 0);
         step(($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1);
      end
      clear_in();
      step(1'b1);
      // drain the scoreboard within a bounded number of cycles
      for (int k = 0; k < 10 && (qa.size() > 0 || qb.size() > 0); k++) @(posedge clk);
      @(negedge clk);
      #1;
      if (qa.size() > 0 || qb.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
